input_debouncer: RTL and testbench
==================================

Name: input_debouncer

Overview:
- Conditions raw board inputs (slide switches, push buttons) into clean, glitch-free logic levels for the downstream gate-level lab logic (AND/OR/XOR gate modules).
- Per channel: 2-flop synchroniser, then a stability counter, then a registered clean level, plus one-cycle rise and fall strobes.
- Sits between the FPGA input pins and the combinational lab logic; one instance serves all gate inputs.

Parameters:
- NUM_INPUTS, 2, number of independent input channels (>=1).
- DEBOUNCE_CYCLES, 50000, consecutive stable cycles required before the clean level changes (1 ms at 50 MHz); legal range >=1.

Ports:
- clk  input  1  system clock; all state is updated on the rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- raw_in  input  NUM_INPUTS  unsynchronised pin levels.
- clean_out  output  NUM_INPUTS  debounced levels; these feed the gate inputs.
- rise_pulse  output  NUM_INPUTS  one-cycle strobe when clean_out goes 0->1.
- fall_pulse  output  NUM_INPUTS  one-cycle strobe when clean_out goes 1->0.
- busy  output  NUM_INPUTS  high while a channel's counter is running (sync differs from clean).

Behaviour:
- Interface: single clock, clk. Reset rst_n is asynchronous and active-low.
- Reset (rst_n=0, asynchronous): sync flops, counters, clean_out, rise_pulse, fall_pulse and busy all go to 0 immediately.
- Synchroniser: sync1 <= raw_in, then sync2 <= sync1. sync2 is the only value the debounce logic compares.
- Counter: width $clog2(DEBOUNCE_CYCLES+1), unsigned, one per channel. Channels are fully independent.
- Per-channel states:
  - STABLE (sync2 == clean_out): counter held at 0; busy=0.
  - COUNTING (sync2 != clean_out): counter +1 per cycle; busy=1.
- Abort: if sync2 returns to clean_out during COUNTING, the counter clears to 0 that edge and the channel returns to STABLE. No pulse, no clean change.
- Commit: on the edge where the channel is COUNTING and counter == DEBOUNCE_CYCLES-1:
  - clean_out <= sync2 and the counter clears.
  - rise_pulse or fall_pulse (matching the direction) is registered high for exactly one cycle.
  - The counter never exceeds DEBOUNCE_CYCLES-1, so there is no wrap-around.
- Latency: a raw step held steady appears on clean_out exactly 2 + DEBOUNCE_CYCLES rising edges after the first edge that samples it. The strobe is coincident with the clean_out change.
- DEBOUNCE_CYCLES=1: the commit happens on the first mismatched cycle, so latency is 3 edges.
- Glitch rejection: any mismatch run shorter than DEBOUNCE_CYCLES cycles (as seen at sync2) produces no output change.
- rise_pulse and fall_pulse are never high together on the same channel. Both are low whenever no commit occurs.
- Reset release with raw_in already high (no inversion): the channel is treated as a normal 0->1 transition. clean_out rises after 2 + DEBOUNCE_CYCLES edges with one rise_pulse.
- Reset asserted mid-count: all state is cleared, and the count restarts from 0 after release.
- Outputs are fully registered; there is no combinational path from raw_in to any output.

Optional Feature:
- Macro: DEBOUNCE_INVERT_INPUTS_EN.
- Defined: raw_in is inverted before sync1, for active-low push buttons. An idle-high pin yields clean_out=0 after reset with no spurious rise_pulse, and pressing the button (pin low) produces clean_out=1 and a rise_pulse.
- Undefined: raw_in is sampled directly (active-high switches). The reset behaviour above applies.
- Reset values of all flops are 0 in both builds.

Test Plan (DEBOUNCE_CYCLES=4, NUM_INPUTS=2, macro undefined unless stated):
- Reset with raw_in=2'b00 -> all outputs 0, and they stay 0 for 20 cycles.
- raw_in[0] steps 0->1 and holds -> clean_out[0]=1 exactly 6 edges later; rise_pulse[0] high that one cycle only; busy[0] high for the 4 preceding cycles.
- raw_in[1] 3-cycle high glitch, then back to 0 -> clean_out[1], rise_pulse[1] and fall_pulse[1] stay 0; busy[1] pulses, then returns to 0.
- Both channels step simultaneously: ch0 0->1 while ch1 1->0 (ch1 previously settled at 1) -> clean_out=2'b01 on the same edge; rise_pulse=2'b01 and fall_pulse=2'b10 for one cycle.
- rst_n pulled low 2 cycles into a count on ch0 -> outputs clear immediately. After release with raw held at 1, clean_out[0] rises 6 edges after release.
- DEBOUNCE_INVERT_INPUTS_EN defined, raw_in idle 2'b11 -> clean_out=0 and no pulses. Driving raw_in[0]=0 gives clean_out[0]=1 plus rise_pulse[0] after 6 edges.

Source files
------------

// File: rtl/input_debouncer.sv
// Per-channel input conditioner: 2-flop synchroniser, stability counter, registered clean level, rise/fall strobes.
// Optional build macro DEBOUNCE_INVERT_INPUTS_EN inverts raw_in ahead of the synchroniser (active-low buttons).
module input_debouncer #(
  parameter int NUM_INPUTS      = 2,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_INPUTS-1:0] raw_in,
  output logic [NUM_INPUTS-1:0] clean_out,
  output logic [NUM_INPUTS-1:0] rise_pulse,
  output logic [NUM_INPUTS-1:0] fall_pulse,
  output logic [NUM_INPUTS-1:0] busy
);

  localparam int CNT_W = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [NUM_INPUTS-1:0] raw_cond;
  logic [NUM_INPUTS-1:0] sync1_q, sync1_d;
  logic [NUM_INPUTS-1:0] sync2_q, sync2_d;
  logic [NUM_INPUTS-1:0] clean_q, clean_d;
  logic [NUM_INPUTS-1:0] rise_q, rise_d;
  logic [NUM_INPUTS-1:0] fall_q, fall_d;
  logic [NUM_INPUTS-1:0] busy_q, busy_d;
  logic [CNT_W-1:0]      cnt_q [NUM_INPUTS];
  logic [CNT_W-1:0]      cnt_d [NUM_INPUTS];

`ifdef DEBOUNCE_INVERT_INPUTS_EN
  assign raw_cond = ~raw_in;
`else
  assign raw_cond = raw_in;
`endif

  // A channel is counting whenever sync2 disagrees with the committed level;
  // agreement at any edge aborts the run, reaching CNT_LAST commits it.
  always_comb begin
    sync1_d = raw_cond;
    sync2_d = sync1_q;
    clean_d = clean_q;
    rise_d  = '0;
    fall_d  = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != clean_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          clean_d[i] = sync2_q[i];
          rise_d[i]  = sync2_q[i];
          fall_d[i]  = ~sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_ONE;
        end
      end
    end
    // Registered view of "counter running" for the cycle that follows this edge.
    busy_d = sync2_d ^ clean_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      clean_q <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      busy_q  <= '0;
      for (int i = 0; i < NUM_INPUTS; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      clean_q <= clean_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      busy_q  <= busy_d;
      for (int i = 0; i < NUM_INPUTS; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign clean_out  = clean_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_input_debouncer.sv
// Scoreboard bench for input_debouncer: stimulus pushes model predictions, a negedge monitor pops and compares.
// Works in both builds; with DEBOUNCE_INVERT_INPUTS_EN the pins are driven as the complement of the logical level.
module tb_input_debouncer;
  localparam int N = 2;
  localparam int D = 4;
`ifdef DEBOUNCE_INVERT_INPUTS_EN
  localparam logic [N-1:0] INV = 2'b11;
`else
  localparam logic [N-1:0] INV = 2'b00;
`endif

  typedef struct packed {
    logic [N-1:0] clean;
    logic [N-1:0] rise;
    logic [N-1:0] fall;
    logic [N-1:0] busy;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [N-1:0] raw_in = INV;
  logic [N-1:0] clean_out, rise_pulse, fall_pulse, busy;

  int n_checks = 0;
  int n_pass = 0;

  exp_t sb_q[$];
  logic [N-1:0] hist[$];   // logical level sampled at each edge since reset release
  logic [N-1:0] mclean = '0;

  input_debouncer #(.NUM_INPUTS(N), .DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .rst_n(rst_n), .raw_in(raw_in),
    .clean_out(clean_out), .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
  endtask

  // Level seen by the debounce logic at edge idx is what the pins showed two edges earlier.
  function automatic logic samp(input int idx, input int ch);
    if (idx < 0) return 1'b0;
    return hist[idx][ch];
  endfunction

  // Reference: a channel flips at edge k when the last D levels it compared all disagree with its clean level.
  task automatic model_edge(input logic [N-1:0] lv);
    exp_t e;
    int k;
    bit all;
    e = '0;
    if (rst_n) begin
      hist.push_back(lv);
      k = hist.size() - 1;
      for (int ch = 0; ch < N; ch++) begin
        all = 1'b1;
        for (int j = 0; j < D; j++)
          if (samp(k - 2 - j, ch) == mclean[ch]) all = 1'b0;
        if (all) begin
          mclean[ch] = ~mclean[ch];
          if (mclean[ch]) e.rise[ch] = 1'b1;
          else            e.fall[ch] = 1'b1;
        end
      end
      e.clean = mclean;
      for (int ch = 0; ch < N; ch++) e.busy[ch] = (samp(k - 1, ch) != mclean[ch]);
    end
    sb_q.push_back(e);
  endtask

  task automatic step(input logic [N-1:0] lv);
    raw_in = lv ^ INV;
    @(posedge clk);
    model_edge(lv);
    #2;
  endtask

  task automatic hold(input logic [N-1:0] lv, input int cycles);
    repeat (cycles) step(lv);
  endtask

  task automatic pulse_reset(input logic [N-1:0] lv, input int cycles);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    raw_in = lv ^ INV;
    #1;
    check("async_reset_clear", {clean_out, rise_pulse, fall_pulse, busy}, '0);
    repeat (cycles) begin
      @(posedge clk);
      model_edge(lv);
      #2;
    end
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    hist.delete();
    mclean = '0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("outputs{clean,rise,fall,busy}",
            {clean_out, rise_pulse, fall_pulse, busy}, e);
      check("rise_fall_exclusive", rise_pulse & fall_pulse, '0);
    end
  end

  initial begin
    logic [N-1:0] lv;
    int len;
    pulse_reset(2'b00, 3);
    hold(2'b00, 20);              // idle after reset
    hold(2'b01, 10);              // ch0 step and hold
    hold(2'b01, 1);
    hold(2'b11, 3);               // ch1 short glitch
    hold(2'b01, 10);
    hold(2'b10, 12);              // ch0 back low, ch1 settles high
    hold(2'b01, 10);              // simultaneous rise ch0 / fall ch1
    hold(2'b00, 10);
    hold(2'b01, 2);               // reset two cycles into a count
    pulse_reset(2'b01, 2);
    hold(2'b01, 12);
    hold(2'b10, 4);               // run of exactly D cycles commits
    hold(2'b01, 3);               // run of D-1 cycles does not
    hold(2'b10, 8);
    for (int s = 0; s < 80; s++) begin
      lv = 2'($urandom_range(0, 3));
      len = $urandom_range(1, 8);
      hold(lv, len);
      if (s == 40) pulse_reset(lv, $urandom_range(1, 3));
    end
    hold(2'b00, 12);
    @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
